mr_csr_arb: RTL
===============

// Module: mr_csr_arb
// PURPOSE
//   Shares the single system-config CSR request port between two requesters:
//   the core pipeline (port C) and the debug module (port D).
//   - Arbitrates round-robin, with an optional debug lock.
//   - Tracks outstanding accepted accesses in an ID FIFO.
//   - Routes each in-order response back to the requester that issued it.
//   - Sits between the core/debug CSR ports and the syscfg CSR slave (port M).
// PARAMETERS
//   DEPTH   2   max accepted-but-unanswered accesses (ID FIFO entries, >=1)
// PORTS
//   clk          in   1        clock
//   rst_n        in   1        asynchronous reset, active-low
//   c_csr_valid  in   1        core request valid
//   c_csr_r      in   1        core read op
//   c_csr_w      in   1        core write op
//   c_csr_addr   in   CSRLEN   core CSR address
//   c_csr_data   in   XLEN     core write data
//   c_csr_wmask  in   XLEN     core write mask
//   c_csr_ready  out  1        core request taken this cycle (if legal)
//   c_csr_legal  out  1        M legality, forwarded while granted, else 0
//   c_csr_fence  out  1        M fence, forwarded while granted, else 0
//   c_rsp_valid  out  1        response for core
//   c_rsp_data   out  XLEN     response data (0 when c_rsp_valid=0)
//   d_*          same set as c_* for the debug requester
//   d_lock       in   1        debug holds exclusive ownership of M
//   m_csr_valid  out  1        to syscfg: request valid
//   m_csr_r/_w   out  1 each   muxed op bits
//   m_csr_addr   out  CSRLEN   muxed address
//   m_csr_data   out  XLEN     muxed write data
//   m_csr_wmask  out  XLEN     muxed write mask
//   m_csr_ready  in   1        syscfg ready
//   m_csr_legal  in   1        syscfg legality (combinational)
//   m_csr_fence  in   1        syscfg fence (combinational)
//   m_rsp_valid  in   1        syscfg response valid; strictly in accept order
//   m_rsp_data   in   XLEN     syscfg response data
//   err          out  1        sticky: response arrived with ID FIFO empty
// BEHAVIOUR
//   Grant (combinational, per cycle):
//   - d_lock=1: only D is eligible. C sees ready/legal/fence=0 even if D idle.
//   - Only one eligible valid: that requester is granted.
//   - Both valid: grant the one NOT recorded in the rr register.
//   - rr resets to D, so C wins the first contention.
//   Muxing and blocking:
//   - M request fields = granted requester's fields.
//   - m_csr_valid = granted valid & !block.
//   - block = (count==DEPTH) & !m_rsp_valid. A pop allows a same-cycle push.
//   Per-requester outputs:
//   - Winner: ready = m_csr_ready & !block; legal and fence forwarded from M.
//   - Loser: ready/legal/fence = 0.
//   - Requesters only act on legal when ready=1.
//   Accept and tagging:
//   - accept = m_csr_valid & m_csr_ready & m_csr_legal.
//   - On accept: push the winner ID (0=C, 1=D) into the FIFO; rr <= winner ID.
//   - A valid but illegal access is not pushed and does not update rr.
//   Response routing (combinational, zero added latency):
//   - m_rsp_valid & FIFO non-empty: pop head, drive X_rsp_valid=1 and
//     X_rsp_data=m_rsp_data for requester X=head; other port gets valid=0, data=0.
//   - End-to-end latency = syscfg latency (1 cycle).
//   - m_rsp_valid with FIFO empty: drop (no rsp_valid), err <= 1 until reset.
//   - Simultaneous push and pop: count unchanged; FIFO order preserved.
//   - count is $clog2(DEPTH+1) bits; read/write pointers wrap modulo DEPTH.
//   Reset (rst_n=0, asynchronous):
//   - FIFO emptied, count=0, rr=D, err=0.
//   - All *_rsp_valid=0 while in reset.
//   - Mid-flight accesses are discarded and responses after reset are not
//     routed (err sets if one arrives).
//   - With idle inputs, all outputs are 0.
// TESTING
//   - C alone: addr=MCYCLE, r=1, legal=1 -> c_csr_ready=1 same cycle;
//     c_rsp_valid=1 next cycle with M data; d_rsp_valid stays 0.
//   - C and D valid every cycle, 4 cycles -> grants C,D,C,D;
//     responses routed to C,D,C,D in order.
//   - d_lock=1, only C valid -> m_csr_valid=0, c_csr_ready=0;
//     release d_lock -> C granted the same cycle.
//   - DEPTH=2, M holds responses: 2 accepts -> 3rd blocked (ready=0);
//     a rsp plus a new req in the same cycle -> pop and push, count stays 2.
//   - Illegal addr (m_csr_legal=0) from D -> no push, rr unchanged,
//     no d_rsp_valid.
//   - Stray m_rsp_valid with FIFO empty -> err=1 and stays 1.
//     rst_n pulsed while 1 access outstanding -> FIFO empty, err=0,
//     late response sets err.

Source files
------------

// File: rtl/mr_csr_arb.sv
// mr_csr_arb: round-robin arbiter sharing the syscfg CSR port between core (C) and debug (D)
//   clk, rst_n           clock, asynchronous active-low reset
//   c_* / d_*            requester CSR request ports; *_rsp_* in-order responses
//   d_lock               debug holds exclusive ownership of M
//   m_*                  syscfg CSR slave port
//   err                  sticky: response arrived with no access outstanding
module mr_csr_arb #(
  parameter int XLEN   = 32,
  parameter int CSRLEN = 12,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_csr_valid,
  input  logic              c_csr_r,
  input  logic              c_csr_w,
  input  logic [CSRLEN-1:0] c_csr_addr,
  input  logic [XLEN-1:0]   c_csr_data,
  input  logic [XLEN-1:0]   c_csr_wmask,
  output logic              c_csr_ready,
  output logic              c_csr_legal,
  output logic              c_csr_fence,
  output logic              c_rsp_valid,
  output logic [XLEN-1:0]   c_rsp_data,
  input  logic              d_csr_valid,
  input  logic              d_csr_r,
  input  logic              d_csr_w,
  input  logic [CSRLEN-1:0] d_csr_addr,
  input  logic [XLEN-1:0]   d_csr_data,
  input  logic [XLEN-1:0]   d_csr_wmask,
  output logic              d_csr_ready,
  output logic              d_csr_legal,
  output logic              d_csr_fence,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rsp_data,
  input  logic              d_lock,
  output logic              m_csr_valid,
  output logic              m_csr_r,
  output logic              m_csr_w,
  output logic [CSRLEN-1:0] m_csr_addr,
  output logic [XLEN-1:0]   m_csr_data,
  output logic [XLEN-1:0]   m_csr_wmask,
  input  logic              m_csr_ready,
  input  logic              m_csr_legal,
  input  logic              m_csr_fence,
  input  logic              m_rsp_valid,
  input  logic [XLEN-1:0]   m_rsp_data,
  output logic              err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr, r_rd;
  logic [DEPTH-1:0] r_fifo;
  logic             r_rr, r_err;
  logic w_c_ok, w_gnt_c, w_gnt_d, w_block, w_push, w_pop, w_head;
  assign w_c_ok  = c_csr_valid & !d_lock;
  // rr holds the last accepted winner (1=D); on contention the other side wins
  assign w_gnt_d = d_csr_valid & (!w_c_ok | !r_rr);
  assign w_gnt_c = w_c_ok & !w_gnt_d;
  // a same-cycle pop frees the slot the new push needs
  assign w_block = (r_count == CW'(DEPTH)) & !m_rsp_valid;
  assign m_csr_valid = (w_gnt_c | w_gnt_d) & !w_block;
  assign m_csr_r     = w_gnt_d ? d_csr_r     : c_csr_r;
  assign m_csr_w     = w_gnt_d ? d_csr_w     : c_csr_w;
  assign m_csr_addr  = w_gnt_d ? d_csr_addr  : c_csr_addr;
  assign m_csr_data  = w_gnt_d ? d_csr_data  : c_csr_data;
  assign m_csr_wmask = w_gnt_d ? d_csr_wmask : c_csr_wmask;
  assign c_csr_ready = w_gnt_c & m_csr_ready & !w_block;
  assign c_csr_legal = w_gnt_c & m_csr_legal;
  assign c_csr_fence = w_gnt_c & m_csr_fence;
  assign d_csr_ready = w_gnt_d & m_csr_ready & !w_block;
  assign d_csr_legal = w_gnt_d & m_csr_legal;
  assign d_csr_fence = w_gnt_d & m_csr_fence;
  assign w_push = m_csr_valid & m_csr_ready & m_csr_legal;
  assign w_pop  = m_rsp_valid & (r_count != '0);
  assign w_head = r_fifo[r_rd];
  assign c_rsp_valid = w_pop & !w_head;
  assign d_rsp_valid = w_pop & w_head;
  assign c_rsp_data  = c_rsp_valid ? m_rsp_data : '0;
  assign d_rsp_data  = d_rsp_valid ? m_rsp_data : '0;
  assign err = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_fifo  <= '0;
      r_rr    <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr] <= w_gnt_d;
        r_wr         <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
        r_rr         <= w_gnt_d;
      end
      if (w_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (m_rsp_valid & (r_count == '0)) r_err <= 1'b1;
    end
  end
endmodule
